// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT sequencer: state encoding, engine selects
// and error codes.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_IDLE   = 2'b00,
      CTRL_LAUNCH = 2'b01,
      CTRL_WAIT   = 2'b10,
      CTRL_DONE   = 2'b11
   } ctrl_state_t;

   localparam logic [1:0] START_FFT8  = 2'b00;
   localparam logic [1:0] START_FFT16 = 2'b01;
   localparam logic [1:0] START_FFT32 = 2'b10;
   localparam logic [1:0] SEL_ILLEGAL = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SEL     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/fft_ctrl_demux.sv
// Decodes an engine select into a one-hot launch vector
// (bit 0 = FFT8, bit 1 = FFT16, bit 2 = FFT32).
module fft_ctrl_demux
   import fft_ctrl_pkg::*;
(
   input  logic       en,
   input  logic [1:0] sel,
   output logic [2:0] start
);

   // The illegal select never reaches here while enabled, but decodes to nothing anyway.
   always_comb begin
      start = 3'b000;
      if (en) begin
         case (sel)
            START_FFT8:  start[0] = 1'b1;
            START_FFT16: start[1] = 1'b1;
            START_FFT32: start[2] = 1'b1;
            default:     start    = 3'b000;
         endcase
      end
   end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer that launches one radix-2 FFT engine per request, waits for
// its done pulse with an optional timeout, and reports status to the host.
module fft_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [1:0] fft_select_i,
   input  logic       done_fft8_i,
   input  logic       done_fft16_i,
   input  logic       done_fft32_i,
   output logic       start_fft8_o,
   output logic       start_fft16_o,
   output logic       start_fft32_o,
   output logic [1:0] active_sel_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [1:0] err_o
);

   localparam bit             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   ctrl_state_t      state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [1:0]       sel_next;
   logic [1:0]       err_next;
   logic             done_sel;
   logic [2:0]       launch_vec;

   // Only the engine that was actually launched can complete the job.
   always_comb begin
      done_sel = 1'b0;
      case (active_sel_o)
         START_FFT8:  done_sel = done_fft8_i;
         START_FFT16: done_sel = done_fft16_i;
         START_FFT32: done_sel = done_fft32_i;
         default:     done_sel = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      count_next = count;
      sel_next   = active_sel_o;
      err_next   = ERR_NONE;
      case (state)
         CTRL_IDLE: begin
            if (start_i) begin
               if (fft_select_i == SEL_ILLEGAL) begin
                  err_next = ERR_SEL;
               end else begin
                  sel_next   = fft_select_i;
                  state_next = CTRL_LAUNCH;
               end
            end
         end
         CTRL_LAUNCH: begin
            count_next = TIMEOUT_LOAD;
            state_next = CTRL_WAIT;
         end
         CTRL_WAIT: begin
            if (TIMEOUT_EN && (count != '0)) begin
               count_next = count - CNT_ONE;
            end
            // A done arriving on the expiry edge still counts as success.
            if (done_sel) begin
               state_next = CTRL_DONE;
            end else if (TIMEOUT_EN && (count == CNT_ONE)) begin
               err_next   = ERR_TIMEOUT;
               state_next = CTRL_IDLE;
            end
         end
         CTRL_DONE: begin
            state_next = CTRL_IDLE;
         end
         default: begin
            state_next = CTRL_IDLE;
         end
      endcase
   end

   // Decoding from the next state keeps the launch pulse aligned with the LAUNCH cycle.
   fft_ctrl_demux u_demux (
      .en    (state_next == CTRL_LAUNCH),
      .sel   (sel_next),
      .start (launch_vec)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= CTRL_IDLE;
         count         <= '0;
         active_sel_o  <= START_FFT8;
         start_fft8_o  <= 1'b0;
         start_fft16_o <= 1'b0;
         start_fft32_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= ERR_NONE;
      end else begin
         state         <= state_next;
         count         <= count_next;
         active_sel_o  <= sel_next;
         start_fft8_o  <= launch_vec[0];
         start_fft16_o <= launch_vec[1];
         start_fft32_o <= launch_vec[2];
         busy_o        <= (state_next != CTRL_IDLE);
         done_o        <= (state_next == CTRL_DONE);
         err_o         <= err_next;
      end
   end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: directed scenarios followed by random
// traffic, all compared against a job-level behavioural model.
module tb_fft_ctrl;

   localparam int T  = 24;
   localparam int CW = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] sel;
   logic       d8, d16, d32;
   logic       s8, s16, s32;
   logic [1:0] active_sel;
   logic       busy;
   logic       done;
   logic [1:0] err;

   int asserts  = 0;
   int failures = 0;

   // Reference model state: job in flight, its age in cycles since acceptance.
   bit         m_in_job;
   bit         m_finishing;
   int         m_age;
   logic [2:0] m_start;
   logic [1:0] m_sel;
   logic [1:0] m_err;
   bit         m_done;

   fft_ctrl #(
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .fft_select_i  (sel),
      .done_fft8_i   (d8),
      .done_fft16_i  (d16),
      .done_fft32_i  (d32),
      .start_fft8_o  (s8),
      .start_fft16_o (s16),
      .start_fft32_o (s32),
      .active_sel_o  (active_sel),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_in_job    = 1'b0;
      m_finishing = 1'b0;
      m_age       = 0;
      m_start     = 3'b000;
      m_sel       = 2'b00;
      m_err       = 2'b00;
      m_done      = 1'b0;
   endtask

   // Expected registered outputs for the cycle after an edge with these inputs.
   task automatic model_edge(input bit s, input logic [1:0] sl, input logic [2:0] dn);
      m_start = 3'b000;
      m_done  = 1'b0;
      m_err   = 2'b00;
      if (!m_in_job) begin
         if (s) begin
            if (sl == 2'b11) begin
               m_err = 2'b01;
            end else begin
               m_in_job = 1'b1;
               m_age    = 1;
               m_sel    = sl;
               m_start  = 3'b001 << sl;
            end
         end
      end else if (m_finishing) begin
         m_in_job    = 1'b0;
         m_finishing = 1'b0;
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (dn[m_sel]) begin
         m_finishing = 1'b1;
         m_done      = 1'b1;
      end else if (m_age - 1 == T) begin
         m_err    = 2'b10;
         m_in_job = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   task automatic check_output(input string tag);
      logic [2:0] sv;
      sv = {s32, s16, s8};
      chk({tag, ".start"},  8'(sv),         8'(m_start));
      chk({tag, ".sel"},    8'(active_sel), 8'(m_sel));
      chk({tag, ".busy"},   8'(busy),       8'(m_in_job));
      chk({tag, ".done"},   8'(done),       8'(m_done));
      chk({tag, ".err"},    8'(err),        8'(m_err));
      chk({tag, ".onehot"}, 8'($countones(sv) <= 1), 8'd1);
   endtask

   task automatic apply_stimulus(input bit s, input logic [1:0] sl, input logic [2:0] dn,
                                 input string tag);
      start = s;
      sel   = sl;
      {d32, d16, d8} = dn;
      @(posedge clk);
      model_edge(s, sl, dn);
      #1;
      check_output(tag);
   endtask

   initial begin
      logic [1:0] jobs [3];
      jobs[0] = 2'b00;
      jobs[1] = 2'b10;
      jobs[2] = 2'b01;

      rst   = 1'b1;
      start = 1'b0;
      sel   = 2'b00;
      d8    = 1'b0;
      d16   = 1'b0;
      d32   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_output("reset");
      rst = 1'b0;

      // Asynchronous reset in the middle of a WAIT, then a stale done.
      apply_stimulus(1'b1, 2'b01, 3'b000, "t1_accept");
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 2'b01, 3'b000, "t1_wait");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_output("t1_async_reset");
      #1;
      rst = 1'b0;
      apply_stimulus(1'b0, 2'b01, 3'b010, "t1_stale_done");
      apply_stimulus(1'b0, 2'b01, 3'b000, "t1_idle");

      // FFT16 job with done after 20 waiting cycles.
      apply_stimulus(1'b1, 2'b01, 3'b000, "t2_accept");
      apply_stimulus(1'b0, 2'b01, 3'b000, "t2_launch");
      for (int i = 0; i < 19; i++) apply_stimulus(1'b0, 2'b01, 3'b000, "t2_wait");
      apply_stimulus(1'b0, 2'b01, 3'b010, "t2_done");
      apply_stimulus(1'b0, 2'b01, 3'b000, "t2_exit");
      apply_stimulus(1'b0, 2'b01, 3'b000, "t2_idle");

      // Illegal select.
      apply_stimulus(1'b1, 2'b11, 3'b000, "t3_illegal");
      apply_stimulus(1'b0, 2'b11, 3'b000, "t3_after");

      // FFT32 timeout, then done landing exactly on the expiry edge.
      apply_stimulus(1'b1, 2'b10, 3'b000, "t4_accept");
      for (int i = 0; i < T + 1; i++) apply_stimulus(1'b0, 2'b10, 3'b000, "t4_wait");
      apply_stimulus(1'b0, 2'b10, 3'b000, "t4_idle");
      apply_stimulus(1'b1, 2'b10, 3'b000, "t4b_accept");
      apply_stimulus(1'b0, 2'b10, 3'b000, "t4b_launch");
      for (int i = 0; i < T - 1; i++) apply_stimulus(1'b0, 2'b10, 3'b000, "t4b_wait");
      apply_stimulus(1'b0, 2'b10, 3'b100, "t4b_expiry_done");
      apply_stimulus(1'b0, 2'b10, 3'b000, "t4b_exit");

      // FFT8 job ignores foreign dones, a done during LAUNCH and a new start.
      apply_stimulus(1'b1, 2'b00, 3'b000, "t5_accept");
      apply_stimulus(1'b0, 2'b00, 3'b001, "t5_launch_done");
      apply_stimulus(1'b0, 2'b00, 3'b100, "t5_fft32_done");
      apply_stimulus(1'b0, 2'b00, 3'b010, "t5_fft16_done");
      apply_stimulus(1'b1, 2'b10, 3'b000, "t5_start_in_wait");
      apply_stimulus(1'b0, 2'b00, 3'b001, "t5_fft8_done");
      apply_stimulus(1'b0, 2'b00, 3'b000, "t5_exit");

      // Back-to-back jobs with start held high.
      for (int j = 0; j < 3; j++) begin
         apply_stimulus(1'b1, jobs[j], 3'b000, "t6_accept");
         apply_stimulus(1'b1, jobs[j], 3'b000, "t6_launch");
         apply_stimulus(1'b1, jobs[j], 3'b000, "t6_wait");
         apply_stimulus(1'b1, jobs[j], 3'b000, "t6_wait");
         apply_stimulus(1'b1, jobs[j], 3'b001 << jobs[j], "t6_done");
         apply_stimulus(1'b1, jobs[j], 3'b000, "t6_exit");
      end
      apply_stimulus(1'b0, 2'b00, 3'b000, "t6_accept_last");
      for (int i = 0; i < 2 * T; i++) apply_stimulus(1'b0, 2'b00, 3'b000, "t6_drain");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bit         rs;
         logic [1:0] rsel;
         logic [2:0] rdn;
         rs   = ($urandom_range(2, 0) == 0);
         rsel = 2'($urandom_range(3, 0));
         rdn  = {($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0),
                 ($urandom_range(9, 0) == 0)};
         apply_stimulus(rs, rsel, rdn, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
